hamming_tx_ctrl: RTL

HAMMING_TX_CTRL -- requirements
Module: hamming_tx_ctrl

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_encode8.sv | 11 +
 rtl/hamming_tx_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared types, constants and the Hamming(12,8) encode function for the
// serial Hamming transmitter. Optional macro: HAMMING_SECDED_EN adds an
// overall parity bit (P13) to the serial frame.
package hamming_pkg;

    localparam int unsigned NDATA = 8;
    localparam int unsigned NCODE = 12;

`ifdef HAMMING_SECDED_EN
    localparam int unsigned NBITS = NCODE + 1;
`else
    localparam int unsigned NBITS = NCODE;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    // Data bits go to the non-power-of-two positions; parity bits sit at 1, 2, 4, 8.
    function automatic logic [NCODE:1] hamming_encode(input logic [NDATA:1] d);
        logic [NCODE:1] c;
        c[3]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[7]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[11] = d[7];
        c[12] = d[8];
        c[1]  = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
        c[2]  = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7];
        c[4]  = d[2] ^ d[3] ^ d[4] ^ d[8];
        c[8]  = d[5] ^ d[6] ^ d[7] ^ d[8];
        return c;
    endfunction

endpackage

// File: rtl/hamming_encode8.sv
// Combinational Hamming(12,8) encoder: data byte in, even-parity codeword out.
module hamming_encode8
    import hamming_pkg::*;
(
    input  logic [NDATA:1] d,
    output logic [NCODE:1] code
);

    assign code = hamming_encode(d);

endmodule

// File: rtl/hamming_tx_ctrl.sv
// Serial Hamming transmitter: accepts a byte, encodes it and shifts the
// codeword out LSB first between a start bit (0) and a stop bit (1).
// Optional macro: HAMMING_SECDED_EN appends overall parity P13 after bit 12.
module hamming_tx_ctrl
    import hamming_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NDATA:1]   D,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NCODE:1]   hammingCode,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    state_t            state_q;
    logic [7:0]        baud_q;
    logic [3:0]        bit_q;
    logic [3:0]        bit_nxt;
    logic [NCODE:1]    code_enc;
    logic [NBITS-1:0]  frame_bits;
    logic              baud_last;
    logic              bit_last;
    logic              accept;

    hamming_encode8 u_encode (
        .d    (D),
        .code (code_enc)
    );

`ifdef HAMMING_SECDED_EN
    assign frame_bits = {^hammingCode, hammingCode};
`else
    assign frame_bits = hammingCode;
`endif

    assign baud_last = (baud_q == 8'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_q == 4'(NBITS - 1));
    assign bit_nxt   = bit_q + 4'd1;
    assign accept    = (state_q == StIdle) && in_valid && in_ready;

    // Frame FSM with baud/bit counters; tx is registered one bit ahead of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            tx          <= 1'b1;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hammingCode <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    tx       <= 1'b1;
                    if (accept) begin
                        state_q     <= StStart;
                        hammingCode <= code_enc;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        tx          <= 1'b0;
                        baud_q      <= '0;
                        bit_q       <= '0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= StData;
                        tx      <= frame_bits[0];
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_last) begin
                            bit_q   <= '0;
                            state_q <= StStop;
                            tx      <= 1'b1;
                        end else begin
                            bit_q <= bit_nxt;
                            tx    <= frame_bits[bit_nxt];
                        end
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q   <= '0;
                        state_q  <= StIdle;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
